// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler.
//   state_e : controller states; the encoding is the phase code shown on debug LEDs
//   CNT_W   : phase timer width; every tick-count parameter must be below 2**CNT_W
//   IDX_A/B : bit positions of street A and street B in the lamp vectors
package traffic_pkg;

  localparam int unsigned CNT_W = 8;

  localparam int unsigned IDX_A = 0;
  localparam int unsigned IDX_B = 1;

  typedef enum logic [2:0] {
    GREEN_A   = 3'd0,
    YELLOW_A  = 3'd1,
    ALLRED_AB = 3'd2,
    GREEN_B   = 3'd3,
    YELLOW_B  = 3'd4,
    ALLRED_BA = 3'd5,
    EMERG     = 3'd6
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled saturating phase timer.
//   clk, rst_n : clock and asynchronous active-low reset
//   tick_i     : count enable (one tick advances the count by one)
//   clear_i    : synchronous clear, has priority over tick_i
//   limit_i    : runtime compare value
//   count_o    : ticks counted since the last clear (saturates at SAT)
//   done_o     : count_o equals limit_i
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned SAT = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SAT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != SAT_C)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == limit_i);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street intersection phase controller advancing on a one-cycle tick enable.
// Arbitrates green time between streets A and B from the traffic sensors with
// minimum/maximum green, yellow and all-red clearance times, plus an emergency
// all-red override. Lamps and phase code are decoded from the state register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick                  : timing enable from the prescaler
//   ta, tb                : street A / B traffic sensors
//   emerg                 : emergency request (level)
//   verde/amarillo/rojo   : green/yellow/red lamps, bit1 = B, bit0 = A
//   phase                 : current state code
// Optional build macro TRAFFIC_PED_REQ_EN adds pedestrian request inputs
// ped_a/ped_b (sticky demand for that street) and the walk[1:0] output.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 15,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  input  logic       emerg,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic       ped_a,
  input  logic       ped_b,
  output logic [1:0] walk,
`endif
  output logic [1:0] verde,
  output logic [1:0] amarillo,
  output logic [1:0] rojo,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALLRED_T - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;
  logic             done;
  logic             clear;
  logic             dem_a;
  logic             dem_b;

  // Every state change restarts the timer, including emergency transitions
  // taken without a tick.
  assign clear = (state_d != state_q);

  phase_timer #(
    .SAT (MAX_GREEN - 1)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_i  (tick),
    .clear_i (clear),
    .limit_i (limit),
    .count_o (count),
    .done_o  (done)
  );

`ifdef TRAFFIC_PED_REQ_EN
  logic [1:0] req_q;
  logic [1:0] req_d;
  logic [1:0] walk_q;
  logic [1:0] walk_d;
  logic       entry_a;
  logic       entry_b;

  assign dem_a   = ta | req_q[IDX_A];
  assign dem_b   = tb | req_q[IDX_B];
  assign entry_a = (state_d == GREEN_A) && (state_q != GREEN_A);
  assign entry_b = (state_d == GREEN_B) && (state_q != GREEN_B);

  always_comb begin
    req_d         = req_q;
    req_d[IDX_A]  = req_q[IDX_A] | ped_a;
    req_d[IDX_B]  = req_q[IDX_B] | ped_b;
    walk_d        = walk_q;
    if (entry_a) begin
      req_d[IDX_A]  = 1'b0;
      walk_d[IDX_A] = req_q[IDX_A] | ped_a;
    end
    if (entry_b) begin
      req_d[IDX_B]  = 1'b0;
      walk_d[IDX_B] = req_q[IDX_B] | ped_b;
    end
    // Walk ends after MIN_GREEN ticks of green or when green is left early.
    if ((state_q == GREEN_A) &&
        ((state_d != GREEN_A) || (tick && (count == MIN_LIM)))) begin
      walk_d[IDX_A] = 1'b0;
    end
    if ((state_q == GREEN_B) &&
        ((state_d != GREEN_B) || (tick && (count == MIN_LIM)))) begin
      walk_d[IDX_B] = 1'b0;
    end
    if (emerg) begin
      req_d  = '0;
      walk_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      walk_q <= '0;
    end else begin
      req_q  <= req_d;
      walk_q <= walk_d;
    end
  end

  assign walk = walk_q;
`else
  assign dem_a = ta;
  assign dem_b = tb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED_BA;
    end else begin
      state_q <= state_d;
    end
  end

  // Green exits early only when the other street demands and this one is idle;
  // with both demanding, the switch waits for the maximum green.
  always_comb begin
    state_d = state_q;
    limit   = MAX_LIM;
    unique case (state_q)
      GREEN_A: begin
        limit = MAX_LIM;
        if (emerg) begin
          state_d = YELLOW_A;
        end else if (tick && dem_b && (((count >= MIN_LIM) && !dem_a) || done)) begin
          state_d = YELLOW_A;
        end
      end
      YELLOW_A: begin
        limit = YEL_LIM;
        if (tick && done) state_d = ALLRED_AB;
      end
      ALLRED_AB: begin
        limit = AR_LIM;
        if (emerg) begin
          state_d = EMERG;
        end else if (tick && done) begin
          state_d = GREEN_B;
        end
      end
      GREEN_B: begin
        limit = MAX_LIM;
        if (emerg) begin
          state_d = YELLOW_B;
        end else if (tick && dem_a && (((count >= MIN_LIM) && !dem_b) || done)) begin
          state_d = YELLOW_B;
        end
      end
      YELLOW_B: begin
        limit = YEL_LIM;
        if (tick && done) state_d = ALLRED_BA;
      end
      ALLRED_BA: begin
        limit = AR_LIM;
        if (emerg) begin
          state_d = EMERG;
        end else if (tick && done) begin
          state_d = GREEN_A;
        end
      end
      EMERG: begin
        limit = AR_LIM;
        if (!emerg) state_d = ALLRED_BA;
      end
      default: state_d = ALLRED_BA;
    endcase
  end

  always_comb begin
    verde    = '0;
    amarillo = '0;
    rojo     = '1;
    unique case (state_q)
      GREEN_A: begin
        verde[IDX_A] = 1'b1;
        rojo[IDX_A]  = 1'b0;
      end
      YELLOW_A: begin
        amarillo[IDX_A] = 1'b1;
        rojo[IDX_A]     = 1'b0;
      end
      GREEN_B: begin
        verde[IDX_B] = 1'b1;
        rojo[IDX_B]  = 1'b0;
      end
      YELLOW_B: begin
        amarillo[IDX_B] = 1'b1;
        rojo[IDX_B]     = 1'b0;
      end
      default: begin
        verde    = '0;
        amarillo = '0;
        rojo     = '1;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default timing parameters
// (MIN_GREEN=5, MAX_GREEN=15, YELLOW_T=3, ALLRED_T=1). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       ta;
  logic       tb;
  logic       emerg;
  logic [1:0] verde;
  logic [1:0] amarillo;
  logic [1:0] rojo;
  logic [2:0] phase;
`ifdef TRAFFIC_PED_REQ_EN
  logic [1:0] walk;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .MIN_GREEN (5),
    .MAX_GREEN (15),
    .YELLOW_T  (3),
    .ALLRED_T  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .ta       (ta),
    .tb       (tb),
    .emerg    (emerg),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_a    (1'b0),
    .ped_b    (1'b0),
    .walk     (walk),
`endif
    .verde    (verde),
    .amarillo (amarillo),
    .rojo     (rojo),
    .phase    (phase)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance n clocks, checking the phase code after each one.
  task automatic expect_phase(input string tag, input int n, input logic [2:0] ph);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq(tag, {5'd0, phase}, {5'd0, ph});
    end
  endtask

  task automatic check_lamps(input string tag, input logic [1:0] v,
                             input logic [1:0] a, input logic [1:0] r);
    check_eq({tag, "_verde"},    {6'd0, verde},    {6'd0, v});
    check_eq({tag, "_amarillo"}, {6'd0, amarillo}, {6'd0, a});
    check_eq({tag, "_rojo"},     {6'd0, rojo},     {6'd0, r});
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst_n = 1'b0;
    ta    = a;
    tb    = b;
    emerg = 1'b0;
    tick  = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, then A-only traffic keeps A green.
    rst_n = 1'b0;
    tick  = 1'b1;
    ta    = 1'b1;
    tb    = 1'b0;
    emerg = 1'b0;
    repeat (3) step();
    check_eq("rst_phase", {5'd0, phase}, 8'd5);
    check_lamps("rst", 2'b00, 2'b00, 2'b11);
    rst_n = 1'b1;
    expect_phase("t1_enter_ga", 1, 3'd0);
    check_lamps("t1_ga", 2'b01, 2'b00, 2'b10);
    expect_phase("t1_hold_ga", 50, 3'd0);
    check_lamps("t1_ga_end", 2'b01, 2'b00, 2'b10);

    // B-only demand: minimum green on A, then full clearance to B.
    do_reset(1'b0, 1'b1);
    expect_phase("t2_ga", 5, 3'd0);
    expect_phase("t2_ya", 3, 3'd1);
    expect_phase("t2_arab", 1, 3'd2);
    expect_phase("t2_gb", 1, 3'd3);
    check_lamps("t2_gb", 2'b10, 2'b00, 2'b01);
    expect_phase("t2_gb_hold", 5, 3'd3);

    // Both streets demanding: maximum green each way, full cycle.
    do_reset(1'b1, 1'b1);
    expect_phase("t3_ga", 15, 3'd0);
    expect_phase("t3_ya", 1, 3'd1);
    check_lamps("t3_ya", 2'b00, 2'b01, 2'b10);
    expect_phase("t3_ya", 2, 3'd1);
    expect_phase("t3_arab", 1, 3'd2);
    check_lamps("t3_arab", 2'b00, 2'b00, 2'b11);
    expect_phase("t3_gb", 15, 3'd3);
    expect_phase("t3_yb", 3, 3'd4);
    expect_phase("t3_arba", 1, 3'd5);
    expect_phase("t3_ga2", 15, 3'd0);
    expect_phase("t3_ya2", 1, 3'd1);

    // Emergency in green without a tick: yellow completes, then EMERG.
    do_reset(1'b1, 1'b0);
    expect_phase("t4_ga", 2, 3'd0);
    tick  = 1'b0;
    emerg = 1'b1;
    expect_phase("t4_em_ya", 1, 3'd1);
    tick  = 1'b1;
    expect_phase("t4_ya", 2, 3'd1);
    expect_phase("t4_arab", 1, 3'd2);
    expect_phase("t4_emerg", 1, 3'd6);
    check_lamps("t4_emerg", 2'b00, 2'b00, 2'b11);
    expect_phase("t4_emerg_hold", 5, 3'd6);
    emerg = 1'b0;
    expect_phase("t4_rel_arba", 1, 3'd5);
    expect_phase("t4_rel_ga", 1, 3'd0);

    // No tick in GREEN_B: state and timer hold.
    do_reset(1'b0, 1'b1);
    expect_phase("t5_ga", 5, 3'd0);
    expect_phase("t5_ya", 3, 3'd1);
    expect_phase("t5_arab", 1, 3'd2);
    expect_phase("t5_gb", 1, 3'd3);
    tick = 1'b0;
    ta   = 1'b1;
    tb   = 1'b0;
    expect_phase("t5_notick", 100, 3'd3);
    tick = 1'b1;
    expect_phase("t5_gb_min", 4, 3'd3);
    expect_phase("t5_yb", 1, 3'd4);
    check_lamps("t5_yb", 2'b00, 2'b10, 2'b01);

    // Asynchronous reset in the middle of YELLOW_B.
    expect_phase("t6_yb", 1, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_lamps("t6_async", 2'b00, 2'b00, 2'b11);
    check_eq("t6_async_phase", {5'd0, phase}, 8'd5);
    step();
    ta    = 1'b1;
    tb    = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("t6_rel_arba", {5'd0, phase}, 8'd5);
    expect_phase("t6_ga", 1, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
